// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C register-bank arbiter: FSM states and owner codes.
package i2c_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RDWAIT = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    localparam logic OWNER_I2C  = 1'b0;
    localparam logic OWNER_CORE = 1'b1;

endpackage

// File: rtl/i2c_arb_wait_cnt.sv
// Saturating wait counter for one requester, with a ">= limit" flag used for
// anti-starvation priority and deadline detection.
module i2c_arb_wait_cnt #(
    parameter int WCW   = 4,
    parameter int LIMIT = 4
) (
    input  logic CLK,
    input  logic POR,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [WCW-1:0] LIMIT_W = WCW'(LIMIT);

    logic [WCW-1:0] count;

    // Clear has precedence; the count parks at all-ones instead of wrapping.
    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign at_limit = (count >= LIMIT_W);

endmodule

// File: rtl/i2c_reg_arbiter.sv
// Two-requester arbiter (I2C slave FSM vs on-chip core) for the single-port
// register bank, with registered memory strobes and a sticky I2C deadline flag.
module i2c_reg_arbiter
    import i2c_pkg::*;
#(
    parameter int AW            = 8,
    parameter int DW            = 8,
    parameter int CORE_MAX_WAIT = 4,
    parameter int I2C_MAX_WAIT  = 6,
    parameter int WCW           = 4
) (
    input  logic          CLK,
    input  logic          POR,
    input  logic          i2c_req,
    input  logic          i2c_we,
    input  logic [AW-1:0] i2c_addr,
    input  logic [DW-1:0] i2c_wdata,
    output logic          i2c_ack,
    output logic [DW-1:0] i2c_rdata,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_ack,
    output logic [DW-1:0] core_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          owner,
    output logic          i2c_late,
    input  logic          late_clr
);

    arb_state_t    state, next_state;
    logic          i2c_grant, core_grant;
    logic          core_prio, i2c_overdue;
    logic          sel_owner, sel_we;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          lat_owner, lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;
    logic          enter_access;

    i2c_arb_wait_cnt #(.WCW(WCW), .LIMIT(CORE_MAX_WAIT)) u_core_wait (
        .CLK      (CLK),
        .POR      (POR),
        .inc      (core_req & ~core_grant),
        .clr      (~core_req | core_grant),
        .at_limit (core_prio)
    );

    i2c_arb_wait_cnt #(.WCW(WCW), .LIMIT(I2C_MAX_WAIT)) u_i2c_wait (
        .CLK      (CLK),
        .POR      (POR),
        .inc      (i2c_req & ~i2c_grant),
        .clr      (~i2c_req | i2c_grant),
        .at_limit (i2c_overdue)
    );

    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // I2C wins ties unless the core has waited long enough to earn one turn.
    always_comb begin
        next_state = state;
        i2c_grant  = 1'b0;
        core_grant = 1'b0;
        case (state)
            ST_IDLE: begin
                if (core_req && (!i2c_req || core_prio)) begin
                    core_grant = 1'b1;
                    next_state = ST_ACCESS;
                end else if (i2c_req) begin
                    i2c_grant  = 1'b1;
                    next_state = ST_ACCESS;
                end
            end
            ST_ACCESS: next_state = lat_we ? ST_DONE : ST_RDWAIT;
            ST_RDWAIT: next_state = ST_DONE;
            ST_DONE:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_owner = core_grant ? OWNER_CORE : OWNER_I2C;
        sel_we    = core_grant ? core_we    : i2c_we;
        sel_addr  = core_grant ? core_addr  : i2c_addr;
        sel_wdata = core_grant ? core_wdata : i2c_wdata;
    end

    assign enter_access = (next_state == ST_ACCESS);

    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            lat_owner <= OWNER_I2C;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (i2c_grant || core_grant) begin
            lat_owner <= sel_owner;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
        end
    end

    // Strobes are decoded from the next state so they line up with ACCESS/DONE.
    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i2c_ack   <= 1'b0;
            core_ack  <= 1'b0;
        end else begin
            mem_en    <= enter_access;
            mem_we    <= enter_access & sel_we;
            mem_addr  <= enter_access ? sel_addr  : '0;
            mem_wdata <= enter_access ? sel_wdata : '0;
            i2c_ack   <= (next_state == ST_DONE) && (lat_owner == OWNER_I2C);
            core_ack  <= (next_state == ST_DONE) && (lat_owner == OWNER_CORE);
        end
    end

    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            i2c_rdata  <= '0;
            core_rdata <= '0;
        end else if (state == ST_RDWAIT) begin
            if (lat_owner == OWNER_CORE) begin
                core_rdata <= mem_rdata;
            end else begin
                i2c_rdata <= mem_rdata;
            end
        end
    end

    // A new miss in the same cycle as late_clr keeps the flag set.
    always_ff @(posedge CLK or posedge POR) begin
        if (POR) begin
            i2c_late <= 1'b0;
        end else if (i2c_overdue && i2c_req && !i2c_grant) begin
            i2c_late <= 1'b1;
        end else if (late_clr) begin
            i2c_late <= 1'b0;
        end
    end

    assign owner = lat_owner;

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Self-checking bench for i2c_reg_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level reference model.
module tb_i2c_reg_arbiter;

    localparam int AW            = 8;
    localparam int DW            = 8;
    localparam int CORE_MAX_WAIT = 4;
    localparam int I2C_MAX_WAIT  = 2;
    localparam int WCW           = 4;
    localparam int WAIT_SAT      = (1 << WCW) - 1;

    logic          CLK = 1'b0;
    logic          POR;
    logic          i2c_req, i2c_we, core_req, core_we, late_clr;
    logic [AW-1:0] i2c_addr, core_addr;
    logic [DW-1:0] i2c_wdata, core_wdata;
    logic          i2c_ack, core_ack, mem_en, mem_we, owner, i2c_late;
    logic [DW-1:0] i2c_rdata, core_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    i2c_reg_arbiter #(
        .AW(AW), .DW(DW), .CORE_MAX_WAIT(CORE_MAX_WAIT),
        .I2C_MAX_WAIT(I2C_MAX_WAIT), .WCW(WCW)
    ) dut (
        .CLK(CLK), .POR(POR),
        .i2c_req(i2c_req), .i2c_we(i2c_we), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
        .i2c_ack(i2c_ack), .i2c_rdata(i2c_rdata),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_ack(core_ack), .core_rdata(core_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner), .i2c_late(i2c_late), .late_clr(late_clr)
    );

    always #5 CLK = ~CLK;

    // Register bank behind the arbiter; unwritten locations read as addr ^ 8'h7E.
    logic [DW-1:0] bank [256];
    bit            written [256];

    always @(posedge CLK) begin
        if (mem_en && mem_we) begin
            bank[mem_addr]    <= mem_wdata;
            written[mem_addr] <= 1'b1;
        end
        if (mem_en && !mem_we) begin
            mem_rdata <= written[mem_addr] ? bank[mem_addr] : (mem_addr ^ 8'h7E);
        end
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_i2c_acks, n_core_acks;

    // Reference model: pos counts cycles since the grant (0 = idle), len is the
    // transaction length (2 for write, 3 for read); ack lands on pos == len.
    int            m_pos, m_len, m_cw, m_iw;
    logic          m_owner, m_we, m_late;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_i2c_rd, m_core_rd;
    logic [DW-1:0] ref_mem [256];

    task automatic model_reset();
        m_pos = 0; m_len = 0; m_cw = 0; m_iw = 0;
        m_owner = 1'b0; m_we = 1'b0; m_late = 1'b0;
        m_addr = '0; m_wdata = '0; m_i2c_rd = '0; m_core_rd = '0;
    endtask

    task automatic model_step();
        bit g_i2c, g_core;
        g_i2c  = 1'b0;
        g_core = 1'b0;
        if (m_pos == 0) begin
            if (i2c_req && core_req) begin
                if (m_cw >= CORE_MAX_WAIT) g_core = 1'b1;
                else                       g_i2c  = 1'b1;
            end else if (i2c_req) begin
                g_i2c = 1'b1;
            end else if (core_req) begin
                g_core = 1'b1;
            end
        end
        m_late = ((m_iw >= I2C_MAX_WAIT) && i2c_req && !g_i2c) || (m_late && !late_clr);
        m_cw = (!core_req || g_core) ? 0 : ((m_cw == WAIT_SAT) ? WAIT_SAT : m_cw + 1);
        m_iw = (!i2c_req || g_i2c)   ? 0 : ((m_iw == WAIT_SAT) ? WAIT_SAT : m_iw + 1);
        if (g_i2c || g_core) begin
            m_owner = g_core;
            m_we    = g_core ? core_we    : i2c_we;
            m_addr  = g_core ? core_addr  : i2c_addr;
            m_wdata = g_core ? core_wdata : i2c_wdata;
            m_len   = m_we ? 2 : 3;
            m_pos   = 1;
            if (m_we) ref_mem[m_addr] = m_wdata;
        end else if (m_pos != 0) begin
            if (m_pos == 2 && m_len == 3) begin
                if (m_owner) m_core_rd = ref_mem[m_addr];
                else         m_i2c_rd  = ref_mem[m_addr];
            end
            m_pos = (m_pos == m_len) ? 0 : m_pos + 1;
        end
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_all();
        logic          e_en, e_done;
        e_en   = (m_pos == 1);
        e_done = (m_pos != 0) && (m_pos == m_len);
        check_output("mem_bus", {14'd0, mem_en, mem_we, mem_addr, mem_wdata},
                     {14'd0, e_en, e_en & m_we, e_en ? m_addr : 8'h00, e_en ? m_wdata : 8'h00});
        check_output("acks", {30'd0, i2c_ack, core_ack}, {30'd0, e_done & ~m_owner, e_done & m_owner});
        check_output("rdata", {16'd0, i2c_rdata, core_rdata}, {16'd0, m_i2c_rd, m_core_rd});
        check_output("owner", {31'd0, owner}, {31'd0, m_owner});
        check_output("i2c_late", {31'd0, i2c_late}, {31'd0, m_late});
    endtask

    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        cyc++;
        n_i2c_acks  += int'(i2c_ack);
        n_core_acks += int'(core_ack);
        check_all();
    endtask

    task automatic apply_stimulus(input logic ir, input logic iw, input logic [7:0] ia,
                                  input logic [7:0] id, input logic cr, input logic cw,
                                  input logic [7:0] ca, input logic [7:0] cd);
        i2c_req = ir;  i2c_we = iw;  i2c_addr = ia;  i2c_wdata = id;
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
    endtask

    initial begin
        int ack_cyc [3];
        for (int a = 0; a < 256; a++) ref_mem[a] = 8'(a) ^ 8'h7E;
        model_reset();
        POR = 1'b1;
        late_clr = 1'b0;
        apply_stimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        repeat (2) @(posedge CLK);
        #1;
        check_all();
        POR = 1'b0;
        tick();

        // I2C write 0x10 <= 0xA5
        apply_stimulus(1, 1, 8'h10, 8'hA5, 0, 0, 8'h00, 8'h00);
        tick();
        check_output("t1_access", {mem_en, mem_we, mem_addr, mem_wdata}, {2'b11, 8'h10, 8'hA5});
        i2c_req = 1'b0;
        tick();
        check_output("t1_ack", {i2c_ack, core_ack}, 2'b10);
        tick();

        // Core read 0x22, bank holds 0x5C
        apply_stimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h22, 8'h00);
        tick();
        core_req = 1'b0;
        tick();
        tick();
        check_output("t2_read", {core_ack, owner, core_rdata}, {2'b11, 8'h5C});
        repeat (2) tick();

        // Both requesters held continuously: neither may starve
        n_i2c_acks = 0;
        n_core_acks = 0;
        for (int i = 0; i < 30; i++) begin
            apply_stimulus(1, 1, 8'($urandom), 8'($urandom), 1, 1, 8'($urandom), 8'($urandom));
            tick();
        end
        check_output("t3_i2c_served", {31'd0, n_i2c_acks > 0}, 32'd1);
        check_output("t3_core_served", {31'd0, n_core_acks > 0}, 32'd1);
        apply_stimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        repeat (4) tick();

        // I2C request stalls behind a core read, then late_clr interplay
        for (int pass = 0; pass < 2; pass++) begin
            late_clr = (pass == 1);
            apply_stimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00);
            tick();
            apply_stimulus(1, 1, 8'h41, 8'h99, 0, 0, 8'h00, 8'h00);
            repeat (3) tick();
            check_output("t4_late_set", {31'd0, i2c_late}, 32'd1);
            late_clr = 1'b0;
            i2c_req = 1'b0;
            repeat (4) tick();
            if (pass == 0) begin
                late_clr = 1'b1;
                tick();
                check_output("t4_late_clr", {31'd0, i2c_late}, 32'd0);
                late_clr = 1'b0;
            end
        end

        // Reset in the middle of a core read
        apply_stimulus(0, 0, 8'h00, 8'h00, 1, 0, 8'h55, 8'h00);
        tick();
        tick();
        #3;
        POR = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge CLK);
        #1;
        POR = 1'b0;
        check_all();
        repeat (2) tick();
        core_req = 1'b0;
        repeat (3) tick();

        // I2C back-to-back writes
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(1, 1, 8'h30 + 8'(k), 8'hC0 + 8'(k), 0, 0, 8'h00, 8'h00);
            tick();
            check_output("t6_addr", {24'd0, mem_addr}, 32'h30 + k);
            tick();
            check_output("t6_ack", {31'd0, i2c_ack}, 32'd1);
            ack_cyc[k] = cyc;
            tick();
        end
        check_output("t6_spacing_a", 32'(ack_cyc[1] - ack_cyc[0]), 32'd3);
        check_output("t6_spacing_b", 32'(ack_cyc[2] - ack_cyc[1]), 32'd3);
        i2c_req = 1'b0;
        repeat (3) tick();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            apply_stimulus($urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom_range(0, 15)),
                           8'($urandom), $urandom_range(0, 2) != 0, 1'($urandom),
                           8'($urandom_range(0, 15)), 8'($urandom));
            late_clr = ($urandom_range(0, 7) == 0);
            tick();
        end
        apply_stimulus(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00);
        late_clr = 1'b0;
        repeat (5) tick();

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
